// File: rtl/led_p2s.sv
// led_p2s: shifts a parallel GPIO word MSB-first onto an external shift-register chain.
// Uses a divided serial clock, followed by a latch strobe, behind a start/busy/done handshake.
module led_p2s #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] PData_in,
  output logic             sclk,
  output logic             sdata,
  output logic             sload,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(DIV) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t state, state_n;
  // MSB goes straight to sdata on accept, so only the remaining bits are shadowed
  logic [WIDTH-2:0] sh, sh_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic sclk_n, sdata_n, sload_n, busy_n, done_n, tick;
  assign tick = dcnt == DW'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      bcnt  <= '0;
      dcnt  <= '0;
      sclk  <= 1'b0;
      sdata <= 1'b0;
      sload <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bcnt  <= bcnt_n;
      dcnt  <= dcnt_n;
      sclk  <= sclk_n;
      sdata <= sdata_n;
      sload <= sload_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    dcnt_n  = tick ? '0 : dcnt + DW'(1);
    sclk_n  = sclk;
    sdata_n = sdata;
    sload_n = sload;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        dcnt_n  = '0;
        sdata_n = start & PData_in[WIDTH-1];
        if (start) begin
          state_n = SHIFT_LO;
          sh_n    = PData_in[WIDTH-2:0];
          bcnt_n  = BW'(WIDTH - 1);
          busy_n  = 1'b1;
          sclk_n  = 1'b0;
        end
      end
      SHIFT_LO: if (tick) begin
        state_n = SHIFT_HI;
        sclk_n  = 1'b1;
      end
      SHIFT_HI: if (tick) begin
        sclk_n = 1'b0;
        if (bcnt == '0) begin
          state_n = LATCH;
          sdata_n = 1'b0;
          sload_n = 1'b1;
        end else begin
          state_n = SHIFT_LO;
          sdata_n = sh[WIDTH-2];
          sh_n    = sh << 1;
          bcnt_n  = bcnt - BW'(1);
        end
      end
      LATCH: if (tick) begin
        state_n = IDLE;
        sload_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_p2s.sv
// tb_led_p2s: directed + random transfers on a 16/4 and an 8/1 instance, checked by a chain-side monitor.
module tb_led_p2s;
  logic clk = 1'b0;
  logic rst, start_b, start_s;
  logic [15:0] pdata_b;
  logic [7:0] pdata_s;
  logic b_sclk, b_sdata, b_sload, b_busy, b_done;
  logic s_sclk, s_sdata, s_sload, s_busy, s_done;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  led_p2s #(.WIDTH(16), .DIV(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .PData_in(pdata_b),
    .sclk(b_sclk), .sdata(b_sdata), .sload(b_sload), .busy(b_busy), .done(b_done)
  );
  led_p2s #(.WIDTH(8), .DIV(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .PData_in(pdata_s),
    .sclk(s_sclk), .sdata(s_sdata), .sload(s_sload), .busy(s_busy), .done(s_done)
  );
  function automatic logic [4:0] outs(input bit sel);
    return sel ? {s_sclk, s_sdata, s_sload, s_busy, s_done} : {b_sclk, b_sdata, b_sload, b_busy, b_done};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Call with start already driven for the accept edge; returns at the negedge of the done cycle.
  task automatic watch(input bit sel, input int w, input int div, input logic [15:0] exp,
                       input logic after_start, input logic [15:0] after_data);
    logic [15:0] word = '0;
    logic [4:0] o;
    logic psc = 1'b0;
    logic psd = 1'bx;
    int rises = 0, bcyc = 0, scyc = 0, err = 0, run = 0, n = 0;
    @(negedge clk);
    if (sel) begin start_s = after_start; pdata_s = after_data[7:0]; end
    else begin start_b = after_start; pdata_b = after_data; end
    o = outs(sel);
    chk("accept_busy_done", {30'd0, o[1], o[0]}, 32'd2);
    while (o[1] && n < 1000) begin
      n++;
      bcyc++;
      run = (o[3] !== psd) ? 1 : run + 1;
      if (o[3] !== psd && o[4]) err++;
      if (o[4] && !psc) begin
        rises++;
        word = {word[14:0], o[3]};
        if (run < div + 1) err++;
      end
      if (o[2]) scyc++;
      if (o[2] && o[4]) err++;
      if (o[0]) err++;
      psc = o[4];
      psd = o[3];
      @(negedge clk);
      o = outs(sel);
    end
    chk("no_timeout", {31'd0, n < 1000}, 32'd1);
    chk("word", {16'd0, word}, {16'd0, exp});
    chk("rises", rises, w);
    chk("busy_len", bcyc, 2 * div * w + div);
    chk("sload_len", scyc, div);
    chk("protocol", err, 0);
    chk("done_end", {27'd0, o}, 32'd1);
  endtask
  initial begin
    logic [15:0] d;
    logic [4:0] o;
    int rises, n, err;
    rst = 1'b1; start_b = 1'b0; start_s = 1'b0; pdata_b = '0; pdata_s = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {outs(0), outs(1)}, 0);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("idle_reset_outs", {outs(0), outs(1)}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_b = 1'b1; pdata_b = 16'hA5C3;
    watch(0, 16, 4, 16'hA5C3, 0, 16'hA5C3);
    @(negedge clk);
    chk("done_width", {27'd0, outs(0)}, 0);
    start_b = 1'b1; pdata_b = 16'hA5C3;
    watch(0, 16, 4, 16'hA5C3, 1, 16'hFFFF);
    watch(0, 16, 4, 16'hFFFF, 0, 16'hFFFF);
    start_b = 1'b1; pdata_b = 16'h0001;
    watch(0, 16, 4, 16'h0001, 0, 16'h0001);
    @(negedge clk);
    start_b = 1'b1; pdata_b = 16'($urandom);
    rises = 0; n = 0;
    o = outs(0);
    while (rises < 7 && n < 500) begin
      @(negedge clk);
      start_b = 1'b0;
      n++;
      if (outs(0) & 5'b10000 && !(o & 5'b10000)) rises++;
      o = outs(0);
    end
    chk("mid_sclk_high", {27'd0, o & 5'b10010}, 32'h12);
    #2 rst = 1'b1;
    #1 chk("mid_reset_outs", {outs(0), outs(1)}, 0);
    @(negedge clk);
    rst = 1'b0;
    err = 0;
    repeat (100) begin
      @(negedge clk);
      if ({outs(0), outs(1)} != 0) err++;
    end
    chk("quiet_after_reset", err, 0);
    start_b = 1'b1; pdata_b = 16'h8000;
    watch(0, 16, 4, 16'h8000, 0, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 16'($urandom);
      start_b = 1'b1; pdata_b = d;
      watch(0, 16, 4, d, 0, 16'($urandom));
    end
    @(negedge clk);
    start_s = 1'b1; pdata_s = 8'h81;
    watch(1, 8, 1, 16'h0081, 0, 16'h0081);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = {8'd0, 8'($urandom)};
      start_s = 1'b1; pdata_s = d[7:0];
      watch(1, 8, 1, d, 0, 16'($urandom));
    end
    @(negedge clk);
    chk("small_done_width", {27'd0, outs(1)}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_p2s.md
# led_p2s

Parallel-to-serial LED driver that sits directly downstream of the GPIO output register. It takes the parallel LED/GPIO word and shifts it MSB-first onto the board's external serial-in shift-register chain, using a divided serial clock and a latch strobe. A start/busy/done handshake lets the bus side trigger a refresh whenever the GPIO word is rewritten.

## Interface
Parameters:
- WIDTH, 16, number of bits shifted per transfer (>= 2)
- DIV, 4, sclk half-period in clk cycles (>= 1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  transfer request; sampled only in IDLE
- PData_in  in  WIDTH  parallel word; captured on the edge that accepts start
- sclk  out  1  serial clock to shift chain; idles low
- sdata  out  1  serial data, MSB first; changes only while sclk is low
- sload  out  1  latch strobe to shift chain, high for DIV cycles after the last bit
- busy  out  1  high from the accept edge until the end of LATCH
- done  out  1  one-cycle completion pulse

## Operation
- Reset value of every output is 0: sclk, sdata, sload, busy, done. Shadow register, bit counter and divide counter are cleared. State is IDLE.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - If start=1 at a rising edge, load the shadow register from PData_in, set busy=1, set sdata=PData_in[WIDTH-1] and sclk=0, and go to SHIFT_LO.
  - Otherwise hold with sdata=0.
- SHIFT_LO:
  - sclk=0 for DIV cycles, then go to SHIFT_HI with sclk=1.
- SHIFT_HI:
  - sclk=1 for DIV cycles.
  - If bits remain, go to SHIFT_LO, drive sclk=0 and present the next bit on sdata on that same edge.
  - After bit 0, go to LATCH with sclk=0, sdata=0 and sload=1.
- LATCH:
  - sload=1 for DIV cycles, then go to IDLE.
  - On that edge busy=0, sload=0 and done=1.
- done is high only in the first IDLE cycle after a transfer.
- start is ignored while busy=1. It is not queued.
- A start in the done cycle is accepted, so transfers run back to back.
- PData_in changes during a transfer have no effect.
- Counter widths: bit counter uses $clog2(WIDTH) bits and divide counter uses $clog2(DIV)+1 bits. Neither counter wraps past its terminal value.

## Timing
- Accept edge to busy=1: visible immediately after that edge (registered, 0 extra cycles).
- busy high duration: exactly 2·DIV·WIDTH + DIV cycles. With the defaults this is 132 cycles.
- Each bit is stable for the full sclk high phase and for DIV cycles before the rising sclk edge, which gives the chain setup = DIV clk cycles.
- The chain samples on sclk rising edges. There are exactly WIDTH rising edges per transfer.
- sload never overlaps sclk=1.
- done rises on the same edge busy falls. Its width is 1 cycle.
- Reset mid-transfer: all outputs drop to 0 immediately (asynchronous), and the FSM returns to IDLE.
  - No partial sload is issued and no done pulse is generated.
  - The first start after rst deasserts begins a full transfer.
- DIV=1 is legal: sclk runs at clk/2 and sload lasts 1 cycle.

## Test plan
- Reset: assert rst mid-idle and while sclk=1 -> all outputs 0 within the same cycle. No activity until start.
- Single transfer, WIDTH=16, DIV=4, PData_in=16'hA5C3, start pulsed 1 cycle:
  - Bits sampled on sclk rising edges reassemble to 16'hA5C3, with exactly 16 rising edges.
  - busy is high for 132 cycles.
  - sload is high for 4 cycles with sclk=0.
  - done is high for 1 cycle.
- Busy ignore: start held high throughout, with PData_in changed to 16'hFFFF after the accept edge:
  - The first transfer still shifts 16'hA5C3.
  - A second transfer with 16'hFFFF starts on the done cycle, so busy low for 0 full cycles between transfers.
- Back-to-back: start asserted exactly in the done cycle with PData_in=16'h0001 -> next transfer begins with no idle gap and shifts 15 zeros then a 1.
- Reset mid-transfer: assert rst after the 7th sclk rising edge:
  - sclk, sdata, sload, busy and done all go to 0 and no done pulse occurs.
  - A following start with 16'h8000 shifts cleanly.
- Parameter corner, WIDTH=8, DIV=1, PData_in=8'h81 -> sclk toggles every cycle, captured byte 8'h81, busy high for 17 cycles, sload 1 cycle.
